// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the fetch-buffer entry type for the fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, used for the entry buffer and the request-address queue
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign count = cnt_q;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(DEPTH);
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rd_d    = flush ? '0 : do_pop ? nxt(rd_q) : rd_q;
    wr_d    = flush ? '0 : do_push ? nxt(wr_q) : wr_q;
    cnt_d   = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, credit-limited imem requests, redirect flush/discard; IF_MISALIGN_TRAP_EN adds misaligned-target trap
module fetch_unit import fetch_pkg::*; #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign,
  input  logic        id_ready
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW+1:0] LIMIT = (CW+2)'(FIFO_DEPTH);
  logic [31:0] pc_q, pc_d, tgt, aq_head;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, buf_cnt, aq_cnt;
  logic [CW+1:0] used;
  logic halted_q, halted_d, trap_q, trap_d, mis;
  logic grant, live_rsp, trap_push, push, pop;
  logic buf_full, buf_empty, aq_full, aq_empty;
  fetch_entry_t push_e, head_e;
`ifdef IF_MISALIGN_TRAP_EN
  assign tgt         = redirect_target;
  assign mis         = |redirect_target[1:0];
  assign if_misalign = head_e.misalign;
`else
  logic unused_bits;
  assign unused_bits = ^{redirect_target[1:0], head_e.misalign};
  assign tgt         = {redirect_target[31:2], 2'b00};
  assign mis         = 1'b0;
  assign if_misalign = 1'b0;
`endif
  assign imem_addr = pc_q;
  assign if_valid  = !reset && !buf_empty;
  assign if_pc     = head_e.pc;
  assign if_instr  = head_e.instr;
  always_comb begin
    used      = (CW+2)'(out_q) + (CW+2)'(buf_cnt) + (CW+2)'(disc_q);
    imem_req  = !reset && !redirect && used < LIMIT && !halted_q;
    grant     = imem_req && imem_gnt;
    live_rsp  = imem_rvalid && disc_q == '0 && !redirect;
    trap_push = trap_q && disc_q == '0 && !redirect;
    push      = live_rsp || trap_push;
    push_e    = trap_push ? {pc_q, NOP_INSTR, 1'b1} : {aq_head, imem_rdata, 1'b0};
    pop       = if_valid && id_ready && !redirect;
    pc_d      = redirect ? tgt : grant ? pc_q + 32'd4 : pc_q;
    out_d     = redirect ? '0 : out_q + CW'(grant) - CW'(live_rsp);
    // stale responses still arrive in order; they are counted off before live ones
    disc_d    = redirect ? disc_q + out_q + CW'(grant) - CW'(imem_rvalid)
                         : disc_q - CW'(imem_rvalid && disc_q != '0);
    halted_d  = redirect ? mis : halted_q;
    trap_d    = redirect ? mis : trap_q && !trap_push;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VECTOR;
      out_q    <= '0;
      disc_q   <= '0;
      halted_q <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      halted_q <= halted_d;
      trap_q   <= trap_d;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fetch_entry_t))) u_buf (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(redirect),
    .din(push_e), .dout(head_e), .count(buf_cnt), .full(buf_full), .empty(buf_empty)
  );
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_addr_q (
    .clk(clk), .reset(reset), .push(grant), .pop(live_rsp), .flush(redirect),
    .din(pc_q), .dout(aq_head), .count(aq_cnt), .full(aq_full), .empty(aq_empty)
  );
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && buf_full && !pop));
  a_aq_tracks:   assert property (@(posedge clk) disable iff (reset) aq_cnt == out_q);
  a_aq_room:     assert property (@(posedge clk) disable iff (reset) !(grant && aq_full));
  a_aq_has_addr: assert property (@(posedge clk) disable iff (reset) !(live_rsp && aq_empty));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven, directed and randomized checks of fetch_unit against a transaction-level model
module tb_fetch_unit;
  import fetch_pkg::*;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int DEPTH = 2;
  logic clk = 0, reset = 1, redirect = 0, imem_gnt = 0, imem_rvalid = 0, id_ready = 0;
  logic [31:0] redirect_target = 0, imem_rdata = 0;
  logic imem_req, if_valid, if_misalign;
  logic [31:0] imem_addr, if_pc, if_instr;
  fetch_unit #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr), .if_misalign(if_misalign), .id_ready(id_ready)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] addr; int rdy; } mreq_t;
  typedef struct { bit r, g, y, req; logic [31:0] addr; bit valid; logic [31:0] pc; } vec_t;
  mreq_t mq[$];
  vec_t tbl[17];
  int tests = 0, fails = 0, cyc = 0, lat_lo = 1, lat_hi = 1, rv_pct = 100;
  int stale, live, avail;
  logic [31:0] key = 0, req_pc, exp_pc, popped_pc;
  bit halted, trap_pend, popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, play memory, check outputs against the transaction model, advance it.
  task automatic cycle(input bit r, g, y, d, input logic [31:0] t);
    bit rv, exp_req, pop;
    int s0;
    logic [31:0] tm;
    @(negedge clk);
    reset = r; imem_gnt = g; id_ready = y; redirect = d; redirect_target = t; rv = 0;
    if (r) mq.delete();
    else if (mq.size() > 0 && mq[0].rdy <= cyc && $urandom_range(99) < rv_pct) begin
      rv = 1;
      imem_rdata = mq[0].addr ^ key;
      void'(mq.pop_front());
    end
    imem_rvalid = rv;
    #1;
    popped = 0;
    if (r) begin
      chk("req_in_reset", {31'b0, imem_req}, 0);
      chk("valid_in_reset", {31'b0, if_valid}, 0);
      stale = 0; live = 0; avail = 0; halted = 0; trap_pend = 0; req_pc = RV; exp_pc = RV;
    end else begin
      exp_req = !d && (stale + live + avail < DEPTH) && !halted;
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      chk("if_valid", {31'b0, if_valid}, {31'b0, avail > 0});
      if (imem_req && g) mq.push_back('{imem_addr, cyc + $urandom_range(lat_hi, lat_lo)});
      if (exp_req && g) chk("imem_addr", imem_addr, req_pc);
      pop = avail > 0 && y && !d;
      if (pop) begin
        popped = 1; popped_pc = if_pc;
        chk("if_pc", if_pc, exp_pc);
        chk("if_instr", if_instr, halted ? NOP_INSTR : exp_pc ^ key);
        chk("if_misalign", {31'b0, if_misalign}, {31'b0, halted});
        exp_pc += 4;
      end
      s0 = stale;
      if (d) begin
        stale = stale + live - (rv ? 1 : 0);
        if (stale < 0) stale = 0;
        live = 0; avail = 0;
`ifdef IF_MISALIGN_TRAP_EN
        tm = t; halted = |t[1:0];
`else
        tm = t & ~32'd3; halted = 0;
`endif
        trap_pend = halted; req_pc = tm; exp_pc = tm;
      end else begin
        if (exp_req && g) begin req_pc += 4; live++; end
        if (rv) begin
          if (stale > 0) stale--;
          else if (live > 0) begin live--; avail++; end
        end
        if (trap_pend && s0 == 0) begin avail++; trap_pend = 0; end
        if (pop) avail--;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
  endtask

  task automatic run_pop(input int budget, output bit found, output logic [31:0] pc);
    found = 0; pc = 0;
    for (int i = 0; i < budget && !found; i++) begin
      cycle(0, 1, 1, 0, 0);
      if (popped) begin found = 1; pc = popped_pc; end
    end
  endtask

  task automatic expect_first(input string name, input logic [31:0] exp);
    bit found;
    logic [31:0] pc;
    run_pop(30, found, pc);
    chk({name, "_seen"}, {31'b0, found}, 1);
    if (found) chk(name, pc, exp);
  endtask

  initial begin
    bit saw;
    int nreq, npop;
    tbl[0]  = '{1, 1, 1, 0, 32'h00, 0, 32'h00};
    tbl[1]  = '{1, 1, 1, 0, 32'h00, 0, 32'h00};
    tbl[2]  = '{0, 1, 1, 1, 32'h00, 0, 32'h00};
    tbl[3]  = '{0, 1, 1, 1, 32'h04, 0, 32'h00};
    tbl[4]  = '{0, 1, 1, 0, 32'h08, 1, 32'h00};
    tbl[5]  = '{0, 1, 1, 1, 32'h08, 1, 32'h04};
    tbl[6]  = '{0, 1, 1, 1, 32'h0C, 0, 32'h00};
    tbl[7]  = '{0, 1, 1, 0, 32'h10, 1, 32'h08};
    tbl[8]  = '{0, 1, 1, 1, 32'h10, 1, 32'h0C};
    tbl[9]  = '{0, 1, 0, 1, 32'h14, 0, 32'h00};
    for (int i = 10; i < 15; i++) tbl[i] = '{0, 1, 0, 0, 32'h18, 1, 32'h10};
    tbl[15] = '{0, 1, 1, 0, 32'h18, 1, 32'h10};
    tbl[16] = '{0, 1, 1, 1, 32'h18, 1, 32'h14};
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].r, tbl[i].g, tbl[i].y, 0, 0);
      chk("tbl_req", {31'b0, imem_req}, {31'b0, tbl[i].req});
      if (tbl[i].req) chk("tbl_addr", imem_addr, tbl[i].addr);
      chk("tbl_valid", {31'b0, if_valid}, {31'b0, tbl[i].valid});
      if (tbl[i].valid) begin
        chk("tbl_pc", if_pc, tbl[i].pc);
        chk("tbl_instr", if_instr, tbl[i].pc);
      end
    end
    // two grants outstanding, then redirect: both responses dropped
    lat_lo = 3; lat_hi = 3;
    do_reset();
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 32'h100);
    expect_first("redir_outstanding", 32'h100);
    // redirect in the same cycle as a response with gnt asserted
    lat_lo = 2; lat_hi = 2;
    do_reset();
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 32'h200);
    expect_first("redir_with_rvalid", 32'h200);
    // back-to-back redirects: last wins
    cycle(0, 1, 1, 1, 32'h300);
    cycle(0, 1, 1, 1, 32'h400);
    expect_first("redir_last_wins", 32'h400);
    // PC wrap past 0xFFFF_FFFC
    lat_lo = 1; lat_hi = 1; saw = 0;
    cycle(0, 1, 1, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 1, 0, 0);
      if (popped && popped_pc == 0) saw = 1;
    end
    chk("pc_wrap_seen", {31'b0, saw}, 1);
`ifdef IF_MISALIGN_TRAP_EN
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 32'h102);
    nreq = 0; npop = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 1, 0, 0);
      nreq += imem_req ? 1 : 0;
      if (popped) begin npop++; chk("trap_pc", popped_pc, 32'h102); end
    end
    chk("trap_no_req", nreq, 0);
    chk("trap_one_entry", npop, 1);
    cycle(0, 1, 1, 1, 32'h200);
    expect_first("trap_resume", 32'h200);
`else
    cycle(0, 1, 1, 1, 32'h103);
    expect_first("target_masked", 32'h100);
    nreq = 0; npop = 0;
`endif
    // randomized traffic against the model
    lat_lo = 1; lat_hi = 3; rv_pct = 60; key = 32'h5A5A_0F0F;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit r, g, y, d;
      logic [31:0] t;
      r = $urandom_range(299) == 0;
      g = $urandom_range(99) < 70;
      y = $urandom_range(99) < 70;
      d = $urandom_range(99) < 4;
      t = $urandom;
`ifdef IF_MISALIGN_TRAP_EN
      if ($urandom_range(4) != 0) t[1:0] = 2'b00;
`endif
      cycle(r, g, y, d, t);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
